// File: rtl/apd_gate_ctrl.sv
// APD gate sequencer: latches a measurement request, freezes the applied dead time,
// runs a series of counting gates and hands each gate's per-channel counts out over valid/ready.
module apd_gate_ctrl #(
   parameter int          NCH    = 2,
   parameter int          CNT_W  = 32,
   parameter int          GATE_W = 32,
   parameter logic [7:0]  DT_RST = 8'd10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [GATE_W-1:0]      gate_len,
   input  logic [15:0]            num_gates,
   input  logic [7:0]             dead_time_cfg,
   input  logic [NCH-1:0]         pulse_in,
   output logic [7:0]             dead_time_APD,
   output logic                   gate,
   output logic                   busy,
   output logic [15:0]            gate_idx,
   output logic [NCH*CNT_W-1:0]   cnt_data,
   output logic                   cnt_valid,
   input  logic                   cnt_ready,
   output logic [NCH-1:0]         overflow
);

   // state | meaning
   // IDLE  | waiting for start; dead time follows dead_time_cfg
   // ARM   | one cycle; clears channel counters, loads gate timer
   // GATE  | counting window; timer counts down to terminal count 0
   // DUMP  | counts presented on cnt_data until cnt_ready
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DUMP} state_t;

   state_t                        state_q, state_d;
   logic [GATE_W-1:0]             len_q, len_d;
   logic [GATE_W-1:0]             tmr_q, tmr_d;
   logic [15:0]                   ngates_q, ngates_d;
   logic [15:0]                   gate_idx_q, gate_idx_d;
   logic [NCH-1:0][CNT_W-1:0]     cnt_q, cnt_d;
   logic [NCH*CNT_W-1:0]          cnt_data_q, cnt_data_d;
   logic [NCH-1:0]                overflow_q, overflow_d;
   logic                          cnt_valid_q, cnt_valid_d;
   logic                          gate_q, gate_d;
   logic                          busy_q, busy_d;
   logic [7:0]                    dt_q, dt_d;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      tmr_d       = tmr_q;
      ngates_d    = ngates_q;
      gate_idx_d  = gate_idx_q;
      cnt_d       = cnt_q;
      cnt_data_d  = cnt_data_q;
      overflow_d  = overflow_q;
      cnt_valid_d = cnt_valid_q;
      gate_d      = gate_q;
      dt_d        = dt_q;

      case (state_q)
         S_IDLE: begin
            dt_d = dead_time_cfg;
            if (start && (num_gates != 16'd0)) begin
               len_d      = (gate_len == '0) ? GATE_W'(1) : gate_len;
               ngates_d   = num_gates;
               overflow_d = '0;
               gate_idx_d = '0;
               state_d    = S_ARM;
            end
         end
         S_ARM: begin
            cnt_d   = '0;
            tmr_d   = len_q - GATE_W'(1);
            gate_d  = 1'b1;
            state_d = S_GATE;
         end
         S_GATE: begin
            for (int k = 0; k < NCH; k++) begin
               if (pulse_in[k]) begin
                  if (&cnt_q[k]) overflow_d[k] = 1'b1;
                  else           cnt_d[k]      = cnt_q[k] + CNT_W'(1);
               end
            end
            if (tmr_q == '0) begin
               // cnt_d already includes a pulse in this last gate cycle
               cnt_data_d  = cnt_d;
               cnt_valid_d = 1'b1;
               gate_d      = 1'b0;
               state_d     = S_DUMP;
            end else begin
               tmr_d = tmr_q - GATE_W'(1);
            end
         end
         S_DUMP: begin
            if (cnt_valid_q && cnt_ready) begin
               cnt_valid_d = 1'b0;
               if (({1'b0, gate_idx_q} + 17'd1) < {1'b0, ngates_q}) begin
                  gate_idx_d = gate_idx_q + 16'd1;
                  state_d    = S_ARM;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d     = S_IDLE;
         cnt_valid_d = 1'b0;
         gate_d      = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= GATE_W'(1);
         tmr_q       <= '0;
         ngates_q    <= '0;
         gate_idx_q  <= '0;
         cnt_q       <= '0;
         cnt_data_q  <= '0;
         overflow_q  <= '0;
         cnt_valid_q <= 1'b0;
         gate_q      <= 1'b0;
         busy_q      <= 1'b0;
         dt_q        <= DT_RST;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         tmr_q       <= tmr_d;
         ngates_q    <= ngates_d;
         gate_idx_q  <= gate_idx_d;
         cnt_q       <= cnt_d;
         cnt_data_q  <= cnt_data_d;
         overflow_q  <= overflow_d;
         cnt_valid_q <= cnt_valid_d;
         gate_q      <= gate_d;
         busy_q      <= busy_d;
         dt_q        <= dt_d;
      end
   end

   assign dead_time_APD = dt_q;
   assign gate          = gate_q;
   assign busy          = busy_q;
   assign gate_idx      = gate_idx_q;
   assign cnt_data      = cnt_data_q;
   assign cnt_valid     = cnt_valid_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_apd_gate_ctrl.sv
// Bench for apd_gate_ctrl: directed runs with random pulse traffic, checked against
// pulse tallies kept per gate (min(n, max) counts, overflow when n exceeds max).
module tb_apd_gate_ctrl;
   localparam int NCH    = 2;
   localparam int CNT_W  = 4;
   localparam int GATE_W = 32;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic [GATE_W-1:0]    gate_len = '0;
   logic [15:0]          num_gates = '0;
   logic [7:0]           dead_time_cfg = 8'd77;
   logic [NCH-1:0]       pulse_in = '0;
   logic [7:0]           dead_time_APD;
   logic                 gate;
   logic                 busy;
   logic [15:0]          gate_idx;
   logic [NCH*CNT_W-1:0] cnt_data;
   logic                 cnt_valid;
   logic                 cnt_ready = 1'b0;
   logic [NCH-1:0]       overflow;

   int checks = 0;
   int errors = 0;
   logic [NCH-1:0] ovf_m = '0;

   apd_gate_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .GATE_W(GATE_W), .DT_RST(8'd10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
      .num_gates(num_gates), .dead_time_cfg(dead_time_cfg), .pulse_in(pulse_in),
      .dead_time_APD(dead_time_APD), .gate(gate), .busy(busy), .gate_idx(gate_idx),
      .cnt_data(cnt_data), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NCH-1:0] rnd_pulses(input int pct);
      logic [NCH-1:0] r;
      for (int k = 0; k < NCH; k++) r[k] = (int'($urandom_range(0, 99)) < pct);
      return r;
   endfunction

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_gate"}, 64'(gate), 64'(0));
      chk({tag, "_valid"}, 64'(cnt_valid), 64'(0));
      chk({tag, "_data"}, 64'(cnt_data), 64'(0));
      chk({tag, "_idx"}, 64'(gate_idx), 64'(0));
      chk({tag, "_ovf"}, 64'(overflow), 64'(0));
      chk({tag, "_dt"}, 64'(dead_time_APD), 64'(10));
   endtask

   // One complete accepted run: L = requested gate_len, G gates, hold cycles of back-pressure per DUMP.
   task automatic run(input int L, input int G, input int hold, input int pct);
      int leff;
      int n[NCH];
      logic [7:0] dt_frz;
      logic [NCH*CNT_W-1:0] exp_data;
      leff   = (L == 0) ? 1 : L;
      dt_frz = dead_time_cfg;
      gate_len = GATE_W'(L);
      num_gates = 16'(G);
      start = 1'b1;
      tick();
      start = 1'b0;
      ovf_m = '0;
      chk("arm_busy", 64'(busy), 64'(1));
      chk("arm_gate", 64'(gate), 64'(0));
      chk("ovf_clear", 64'(overflow), 64'(0));
      for (int g = 0; g < G; g++) begin
         pulse_in = rnd_pulses(pct);
         tick();
         for (int k = 0; k < NCH; k++) n[k] = 0;
         for (int i = 0; i < leff; i++) begin
            chk("gate_hi", 64'(gate), 64'(1));
            chk("gate_valid_lo", 64'(cnt_valid), 64'(0));
            pulse_in = rnd_pulses(pct);
            for (int k = 0; k < NCH; k++) if (pulse_in[k]) n[k]++;
            start = 1'($urandom_range(0, 1));
            gate_len = GATE_W'($urandom);
            num_gates = 16'($urandom);
            if (i == leff / 2) dead_time_cfg = dt_frz + 8'd30;
            tick();
         end
         start = 1'b0;
         for (int k = 0; k < NCH; k++) begin
            exp_data[k*CNT_W +: CNT_W] = CNT_W'((n[k] > CMAX) ? CMAX : n[k]);
            if (n[k] > CMAX) ovf_m[k] = 1'b1;
         end
         chk("dump_gate_lo", 64'(gate), 64'(0));
         chk("dump_valid", 64'(cnt_valid), 64'(1));
         chk("cnt_data", 64'(cnt_data), 64'(exp_data));
         chk("dump_idx", 64'(gate_idx), 64'(g));
         chk("dt_frozen", 64'(dead_time_APD), 64'(dt_frz));
         chk("dump_ovf", 64'(overflow), 64'(ovf_m));
         for (int h = 0; h < hold; h++) begin
            cnt_ready = 1'b0;
            pulse_in = rnd_pulses(pct);
            tick();
            chk("hold_valid", 64'(cnt_valid), 64'(1));
            chk("hold_data", 64'(cnt_data), 64'(exp_data));
         end
         cnt_ready = 1'b1;
         pulse_in = rnd_pulses(pct);
         tick();
         cnt_ready = 1'b0;
         chk("valid_drop", 64'(cnt_valid), 64'(0));
         if (g < G - 1) begin
            chk("idx_next", 64'(gate_idx), 64'(g + 1));
            chk("busy_arm", 64'(busy), 64'(1));
            chk("gate_arm", 64'(gate), 64'(0));
         end else begin
            chk("busy_done", 64'(busy), 64'(0));
            chk("idx_last", 64'(gate_idx), 64'(g));
            chk("ovf_hold", 64'(overflow), 64'(ovf_m));
            chk("dt_idle0", 64'(dead_time_APD), 64'(dt_frz));
            pulse_in = '0;
            tick();
            chk("dt_idle1", 64'(dead_time_APD), 64'(dead_time_cfg));
         end
      end
   endtask

   // Abort in gate cycle cyc (1-based) with start also high.
   task automatic abort_run(input int L, input int cyc, input int pct);
      int n[NCH];
      gate_len = GATE_W'(L);
      num_gates = 16'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      ovf_m = '0;
      for (int k = 0; k < NCH; k++) n[k] = 0;
      pulse_in = '0;
      tick();
      for (int i = 1; i < cyc; i++) begin
         pulse_in = rnd_pulses(pct);
         for (int k = 0; k < NCH; k++) if (pulse_in[k]) n[k]++;
         tick();
      end
      chk("abort_pre_gate", 64'(gate), 64'(1));
      pulse_in = '0;
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      for (int k = 0; k < NCH; k++) if (n[k] > CMAX) ovf_m[k] = 1'b1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_gate", 64'(gate), 64'(0));
      chk("abort_valid", 64'(cnt_valid), 64'(0));
      chk("abort_ovf", 64'(overflow), 64'(ovf_m));
      for (int i = 0; i < L + 4; i++) begin
         cnt_ready = 1'($urandom_range(0, 1));
         tick();
         chk("post_abort_valid", 64'(cnt_valid), 64'(0));
         chk("post_abort_busy", 64'(busy), 64'(0));
      end
      cnt_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("dt_follow", 64'(dead_time_APD), 64'(77));
      dead_time_cfg = 8'd10;
      tick();

      gate_len = 32'd5;
      num_gates = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ng0_busy", 64'(busy), 64'(0));
      chk("ng0_gate", 64'(gate), 64'(0));
      tick();
      chk("ng0_busy2", 64'(busy), 64'(0));

      run(10, 1, 0, 30);
      run(4, 3, 5, 50);
      run(0, 1, 0, 50);
      run(20, 1, 0, 100);
      tick();
      tick();
      chk("ovf_sticky", 64'(overflow), 64'(2'b11));
      run(3, 1, 0, 0);
      for (int r = 0; r < 4; r++)
         run(int'($urandom_range(1, 12)), int'($urandom_range(1, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 100)));

      abort_run(8, 3, 50);
      abort_run(30, 19, 100);

      gate_len = 32'd3;
      num_gates = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      pulse_in = '0;
      tick();
      pulse_in = '1;
      repeat (3) tick();
      pulse_in = '0;
      chk("pre_rst_valid", 64'(cnt_valid), 64'(1));
      chk("pre_rst_data", 64'(cnt_data), 64'(8'h33));
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
